// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_state_e;

    localparam int DEFAULT_DATA_BITS  = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;

    localparam int VOTE_IDX_A      = 7;
    localparam int VOTE_IDX_B      = 8;
    localparam int VOTE_IDX_C      = 9;
    localparam int STOP_DECIDE_IDX = 9;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - valid/ready byte handoff from the receiver to its consumer
interface uart_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser with selectable reset value
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic stage1_q, stage1_d;
    logic stage2_q, stage2_d;

    always_comb begin
        stage1_d = d;
        stage2_d = stage1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage1_q <= RESET_VAL;
            stage2_q <= RESET_VAL;
        end else begin
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
        end
    end

    assign q = stage2_q;
endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver, 16x oversampled with mid-bit majority vote
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rxClk,
    input  logic                rx,
    uart_receiver_if.master     rx_if,
    output logic                frameError,
    output logic                overrun,
    output logic                busy
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

    logic rx_s, rxclk_s, tick;
    logic vote_now, vote_full;

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           samp_q, samp_d;
    logic                 armed_q, armed_d;
    logic                 rxclk_prev_q, rxclk_prev_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 deliver;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync_rx    (.clk(clk), .reset(reset), .d(rx),    .q(rx_s));
    uart_sync2 #(.RESET_VAL(1'b0)) u_sync_rxclk (.clk(clk), .reset(reset), .d(rxClk), .q(rxclk_s));

    assign tick      = rxclk_s & ~rxclk_prev_q;
    assign vote_full = majority3(samp_q[0], samp_q[1], samp_q[2]);
    // The stop bit is judged on the third sample's own tick, so it is taken live.
    assign vote_now  = majority3(samp_q[0], samp_q[1], rx_s);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        samp_d       = samp_q;
        armed_d      = armed_q;
        rxclk_prev_d = rxclk_s;
        data_d       = data_q;
        valid_d      = valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        deliver      = 1'b0;

        if (tick) begin
            // A start is only accepted once the line has been seen idle, so a
            // reset that lands mid-frame cannot lock onto a data bit.
            if (rx_s) armed_d = 1'b1;
            if (state_q != ST_IDLE) begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                if (cnt_q == CNT_W'(VOTE_IDX_A)) samp_d[0] = rx_s;
                if (cnt_q == CNT_W'(VOTE_IDX_B)) samp_d[1] = rx_s;
                if (cnt_q == CNT_W'(VOTE_IDX_C)) samp_d[2] = rx_s;
            end
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s && armed_q) begin
                        state_d = ST_START;
                        cnt_d   = CNT_W'(1);
                    end
                end
                ST_START: begin
                    if (cnt_q == CNT_LAST) begin
                        if (vote_full) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DATA;
                            bit_d   = '0;
                            cnt_d   = '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        shift_d = {vote_full, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BIT_W'(DATA_BITS - 1)) state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == CNT_W'(STOP_DECIDE_IDX)) begin
                        if (vote_now) begin
                            deliver = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rx_s) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (deliver) begin
            if (!valid_q || rx_if.ready) begin
                data_d  = shift_d;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && rx_if.ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            samp_q       <= '0;
            armed_q      <= 1'b0;
            rxclk_prev_q <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            samp_q       <= samp_d;
            armed_q      <= armed_d;
            rxclk_prev_q <= rxclk_prev_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_if.data  = data_q;
    assign rx_if.valid = valid_q;
    assign frameError  = frame_err_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed vector bench for uart_receiver
module tb_uart_receiver;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rxClk = 1'b0;
    logic rx = 1'b1;
    logic frameError, overrun, busy;

    uart_receiver_if #(.DATA_BITS(8)) rx_if ();

    uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .rxClk     (rxClk),
        .rx        (rx),
        .rx_if     (rx_if),
        .frameError(frameError),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int div = 0;
    always @(negedge clk) begin
        div = div + 1;
        if (div == 4) begin
            div = 0;
            rxClk = ~rxClk;
        end
    end

    int n_vrise = 0, n_vfall = 0, n_vcyc = 0, n_fe = 0, n_ovr = 0;
    logic [7:0] last_data = 8'h00;
    logic v_prev = 1'b0;
    always @(negedge clk) begin
        if (rx_if.valid && !v_prev) begin
            n_vrise = n_vrise + 1;
            last_data = rx_if.data;
        end
        if (!rx_if.valid && v_prev) n_vfall = n_vfall + 1;
        if (rx_if.valid) n_vcyc = n_vcyc + 1;
        if (frameError) n_fe = n_fe + 1;
        if (overrun) n_ovr = n_ovr + 1;
        v_prev = rx_if.valid;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Sends one frame aligned to rxClk rising edges; rst_idx pulses reset in the
    // middle of that frame bit, rdy_pulse raises ready on the stop-bit delivery clk.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int low_after,
                              input int rst_idx, input bit rdy_pulse);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        @(posedge rxClk);
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            if (i == rst_idx) begin
                repeat (8) @(posedge rxClk);
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                repeat (8) @(posedge rxClk);
            end else if (i == 9 && rdy_pulse) begin
                repeat (9) @(posedge rxClk);
                repeat (2) @(negedge clk);
                rx_if.ready = 1'b1;
                @(negedge clk);
                rx_if.ready = 1'b0;
                repeat (7) @(posedge rxClk);
            end else begin
                repeat (16) @(posedge rxClk);
            end
        end
        if (low_after > 0) begin
            rx = 1'b0;
            repeat (low_after) @(posedge rxClk);
        end
        rx = 1'b1;
        repeat (4) @(posedge rxClk);
    endtask

    typedef struct {
        logic [7:0] payload;
        logic       stop;
        int         low_after;
        int         exp_rise;
        int         exp_vcyc;
        int         exp_fe;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_rise, b_vcyc, b_fe, b_ovr, b_vfall;

        vecs[0] = '{8'h55, 1'b1, 0,  1, 1, 0, 8'h55};
        vecs[1] = '{8'h00, 1'b1, 0,  1, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 0,  1, 1, 0, 8'hFF};
        vecs[3] = '{8'h80, 1'b1, 0,  1, 1, 0, 8'h80};
        vecs[4] = '{8'hA3, 1'b0, 40, 0, 0, 1, 8'h00};
        vecs[5] = '{8'h0F, 1'b1, 0,  1, 1, 0, 8'h0F};

        rx_if.ready = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_valid", 32'(rx_if.valid), 32'd0);
        check("reset_data", 32'(rx_if.data), 32'h00);
        check("reset_fe", 32'(frameError), 32'd0);
        check("reset_ovr", 32'(overrun), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        repeat (4) @(posedge rxClk);

        for (int v = 0; v < 6; v++) begin
            b_rise = n_vrise; b_vcyc = n_vcyc; b_fe = n_fe; b_ovr = n_ovr;
            send_frame(vecs[v].payload, vecs[v].stop, vecs[v].low_after, -1, 1'b0);
            check($sformatf("vec%0d_rise", v), 32'(n_vrise - b_rise), 32'(vecs[v].exp_rise));
            check($sformatf("vec%0d_vcyc", v), 32'(n_vcyc - b_vcyc), 32'(vecs[v].exp_vcyc));
            check($sformatf("vec%0d_fe", v), 32'(n_fe - b_fe), 32'(vecs[v].exp_fe));
            check($sformatf("vec%0d_ovr", v), 32'(n_ovr - b_ovr), 32'd0);
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
            if (vecs[v].exp_rise > 0)
                check($sformatf("vec%0d_data", v), 32'(last_data), 32'(vecs[v].exp_data));
        end

        b_rise = n_vrise; b_fe = n_fe;
        @(posedge rxClk);
        rx = 1'b0;
        repeat (5) @(posedge rxClk);
        rx = 1'b1;
        check("glitch_busy_high", 32'(busy), 32'd1);
        repeat (16) @(posedge rxClk);
        check("glitch_busy_low", 32'(busy), 32'd0);
        check("glitch_rise", 32'(n_vrise - b_rise), 32'd0);
        check("glitch_fe", 32'(n_fe - b_fe), 32'd0);

        @(negedge clk);
        rx_if.ready = 1'b0;
        b_rise = n_vrise; b_ovr = n_ovr;
        send_frame(8'h11, 1'b1, 0, -1, 1'b0);
        check("ovr_first_valid", 32'(rx_if.valid), 32'd1);
        check("ovr_first_data", 32'(rx_if.data), 32'h11);
        send_frame(8'h22, 1'b1, 0, -1, 1'b0);
        check("ovr_pulse", 32'(n_ovr - b_ovr), 32'd1);
        check("ovr_rise", 32'(n_vrise - b_rise), 32'd1);
        check("ovr_held_data", 32'(rx_if.data), 32'h11);
        @(negedge clk);
        rx_if.ready = 1'b1;
        @(negedge clk);
        rx_if.ready = 1'b0;
        check("ovr_drain_valid", 32'(rx_if.valid), 32'd0);
        check("ovr_drain_data", 32'(rx_if.data), 32'h11);

        send_frame(8'h33, 1'b1, 0, -1, 1'b0);
        check("same_clk_first", 32'(rx_if.data), 32'h33);
        b_vfall = n_vfall; b_ovr = n_ovr;
        send_frame(8'h44, 1'b1, 0, -1, 1'b1);
        check("same_clk_valid", 32'(rx_if.valid), 32'd1);
        check("same_clk_data", 32'(rx_if.data), 32'h44);
        check("same_clk_no_fall", 32'(n_vfall - b_vfall), 32'd0);
        check("same_clk_no_ovr", 32'(n_ovr - b_ovr), 32'd0);
        @(negedge clk);
        rx_if.ready = 1'b1;
        @(negedge clk);
        check("same_clk_drain", 32'(rx_if.valid), 32'd0);

        b_rise = n_vrise; b_fe = n_fe; b_ovr = n_ovr;
        send_frame(8'hC6, 1'b1, 0, 5, 1'b0);
        repeat (20) @(posedge rxClk);
        check("rst_no_rise", 32'(n_vrise - b_rise), 32'd0);
        check("rst_no_fe", 32'(n_fe - b_fe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        send_frame(8'h7E, 1'b1, 0, -1, 1'b0);
        check("rst_next_rise", 32'(n_vrise - b_rise), 32'd1);
        check("rst_next_data", 32'(last_data), 32'h7E);
        check("rst_next_ovr", 32'(n_ovr - b_ovr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
# uart_receiver

UART 8N1 receive stage that sits directly downstream of the baud rate generator. It runs entirely on the board clock `clk`. It treats the generator's `rxClk` (16× oversample clock) as a data signal and edge-detects it into a one-`clk` sample tick. Each serial frame is recovered by majority vote at mid-bit and handed to the downstream consumer (e.g. AES input packer) over a valid/ready holding register.

## Interface
- `DATA_BITS`, 8, payload bits per frame, LSB first
- `OVERSAMPLE`, 16, sample ticks per bit; must match the generator's 16× rx rate
- `clk` input 1 board clock; all logic on its rising edge
- `reset` input 1 synchronous, active-high reset
- `rxClk` input 1 oversample clock from the baud rate generator, sampled as data
- `rx` input 1 asynchronous serial line, idle high
- `data` output DATA_BITS received byte, valid while `valid`=1
- `valid` output 1 holding register full
- `ready` input 1 consumer accepts `data` when `valid && ready`
- `frameError` output 1 one-cycle pulse: stop bit sampled low
- `overrun` output 1 one-cycle pulse: byte completed while register still full
- `busy` output 1 high in any state other than IDLE

## Operation
- Synchronisers: `rx` and `rxClk` each pass through 2 flops (reset value 1 for `rx`, 0 for `rxClk`). `tick` = sync_rxClk & ~sync_rxClk_d, one `clk` wide.
- All FSM and counters advance only on `tick`. Handshake logic runs every `clk`.
- `sampleCnt` is $clog2(OVERSAMPLE) bits and wraps to 0 after OVERSAMPLE-1. `bitIdx` is $clog2(DATA_BITS+1) bits.
- Majority vote: samples taken at sampleCnt 7, 8, 9; bit = 1 if ≥2 of the 3 samples are 1.
- States:
  - IDLE: on tick with rx=0 → START, sampleCnt←1.
  - START: at sampleCnt=15, if vote=1 (glitch) → IDLE, no flags; else → DATA, bitIdx←0, sampleCnt←0.
  - DATA: at sampleCnt=15, shift vote into MSB of shift reg (LSB-first reception), bitIdx++; at bitIdx=DATA_BITS-1 → STOP.
  - STOP: at sampleCnt=9 decide (half-bit early for resync margin).
    - vote=1 → deliver, → IDLE.
    - vote=0 → pulse `frameError`, discard byte, → BREAK.
  - BREAK: on tick with rx=1 → IDLE. A held-low line never produces false frames.
- Deliver:
  - if `valid`=0 or (`valid && ready`) in the same `clk`: load `data`, `valid`←1.
  - else: pulse `overrun`, drop the new byte, keep the held byte.
- `valid && ready` without delivery: `valid`←0 next `clk`. `data` holds its last value.

## Timing
- Reset: state IDLE, counters 0, `data`=0, `valid`=0, `frameError`=0, `overrun`=0, `busy`=0.
- Reset asserted mid-frame abandons the frame with no flags. The next byte needs a fresh start edge.
- `valid` rises 1 `clk` after the tick at STOP sampleCnt 9, i.e. (1+DATA_BITS)×16+9 ticks after the first low tick, plus 2–3 `clk` of synchroniser delay.
- `frameError`/`overrun` are exactly 1 `clk` wide and coincide with the cycle `valid`/`data` would have updated.
- Back-to-back frames: the next start bit may be detected on the first tick after STOP returns to IDLE.
- Tick period in system at 50 MHz/9600 baud is 326 `clk`. The RTL must work for any tick spacing ≥ 4 `clk`.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP, BREAK)
  - default DATA_BITS, OVERSAMPLE
  - vote sample indices 7/8/9, STOP decide index 9
- Sub-module `uart_sync2` (2-flop synchroniser, parameterised reset value), instantiated for `rx` and `rxClk`.
- Vote is inline combinational logic.

## Test plan
- `rxClk` toggled every 4 `clk`, frame 0x55 LSB-first with valid stop, `ready`=1 → `valid` pulse 1 `clk`, `data`=0x55, no flags.
- Start bit low for only 5 ticks, then high → return to IDLE, no `valid`, no `frameError`, `busy` falls.
- Frame 0xA3 with stop bit low, then line held low 40 ticks, then high, then frame 0x0F → one `frameError` pulse, no spurious frames, then `data`=0x0F.
- `ready`=0; send 0x11 then 0x22 → `valid`=1 with `data`=0x11, `overrun` pulse at the end of 0x22. Raise `ready` → `valid` drops, `data` stays 0x11.
- `ready` asserted exactly on the delivery `clk` of the second byte (0x33 held, 0x44 arriving) → no `overrun`, `valid` stays 1, `data`=0x44.
- `reset` pulsed for 1 `clk` mid-DATA of 0xC6, then full frame 0x7E → no output for 0xC6, `data`=0x7E.
